// File: rtl/hiscore_ram_arbiter_pkg.sv
// hiscore_arb_pkg: shared types and defaults for the hiscore RAM arbiter.
//   arb_state_t      - arbiter FSM state encoding
//   DEF_*            - default parameter values
//   cnt_width()      - register width needed to hold 0..max_val (at least 1)
package hiscore_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_WIN,
      ST_SETTLE,
      ST_GRANT,
      ST_RELEASE
   } arb_state_t;

   localparam int DEF_ADDR_WIDTH     = 10;
   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_SETTLE_CYCLES  = 4;
   localparam int DEF_RELEASE_CYCLES = 2;
   localparam int DEF_TIMEOUT_CYCLES = 24'hFFFFFF;
   localparam int DEF_USE_VBLANK     = 0;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/hiscore_ram_arbiter_if.sv
// hiscore_ram_arbiter_if: CPU port, hiscore engine port and physical RAM port
// of the hiscore RAM arbiter.
//   slave  - arbiter view (muxes CPU / hiscore onto the RAM)
//   master - environment view (CPU, hiscore engine and RAM models)
interface hiscore_ram_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_dout;
   logic                  cpu_we;
   logic [DATA_WIDTH-1:0] cpu_din;
   logic                  hs_access;
   logic                  hs_write;
   logic [ADDR_WIDTH-1:0] hs_addr;
   logic [DATA_WIDTH-1:0] hs_dout;
   logic [DATA_WIDTH-1:0] hs_din;
   logic                  vblank;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_dout;
   logic                  pause_cpu;
   logic                  hs_grant;
   logic                  timeout_err;

   modport slave (
      input  cpu_addr, cpu_dout, cpu_we, hs_access, hs_write, hs_addr, hs_dout,
             vblank, ram_dout,
      output cpu_din, hs_din, ram_addr, ram_din, ram_we, pause_cpu, hs_grant,
             timeout_err
   );

   modport master (
      output cpu_addr, cpu_dout, cpu_we, hs_access, hs_write, hs_addr, hs_dout,
             vblank, ram_dout,
      input  cpu_din, hs_din, ram_addr, ram_din, ram_we, pause_cpu, hs_grant,
             timeout_err
   );
endinterface

// File: rtl/hiscore_ram_arbiter_down_counter.sv
// hs_down_counter: loadable down-counter that stops at zero.
//   clk, reset - clock, async active-high reset
//   load       - load load_val (takes priority over dec)
//   dec        - decrement by one, saturating at zero
//   zero       - count is zero
module hs_down_counter #(
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter: shares one game-RAM port between the CPU and the
// hiscore engine. A hiscore request pauses the CPU, waits for the bus to
// settle, then hands address/data/write-enable to the hiscore side.
//   clk, reset - clock, async active-high reset
//   bus        - slave view of hiscore_ram_arbiter_if (CPU, hiscore, RAM ports,
//                pause_cpu / hs_grant / timeout_err status)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | CPU owns the RAM, no pause
// WAIT_WIN   | request pending, waiting for vblank (USE_VBLANK only)
// SETTLE     | CPU paused, letting the bus settle before the grant
// GRANT      | hiscore side owns the RAM, writes pass through
// RELEASE    | hiscore side keeps the mux with writes forced off
module hiscore_ram_arbiter
   import hiscore_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int USE_VBLANK     = DEF_USE_VBLANK
)(
   input logic                   clk,
   input logic                   reset,
   hiscore_ram_arbiter_if.slave  bus
);
   localparam int CNT_MAX = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
   localparam int CW      = cnt_width(CNT_MAX);
   localparam int TW      = cnt_width(TIMEOUT_CYCLES);

   // The entry edge is the first cycle spent in SETTLE/RELEASE, hence the -1.
   localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] RELEASE_LOAD = CW'((RELEASE_CYCLES > 0) ? RELEASE_CYCLES - 1 : 0);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   arb_state_t            state;
   logic                  pause_q;
   logic                  grant_q;
   logic                  err_q;
   logic                  lockout;
   logic [TW-1:0]         tcnt;
   logic                  enter_settle;
   logic                  timeout_hit;
   logic                  leave_grant;
   logic                  cnt_load;
   logic [CW-1:0]         cnt_load_val;
   logic                  cnt_dec;
   logic                  cnt_zero;
   logic                  sel_hs;
   logic [ADDR_WIDTH-1:0] addr_mux;
   logic [DATA_WIDTH-1:0] din_mux;
   logic                  we_mux;

   always_comb begin
      enter_settle = 1'b0;
      if (bus.hs_access) begin
         if (state == ST_IDLE && !lockout && USE_VBLANK == 0)
            enter_settle = 1'b1;
         if (state == ST_WAIT_WIN && bus.vblank)
            enter_settle = 1'b1;
      end
      timeout_hit  = (state == ST_GRANT) && (tcnt == TIMEOUT_LAST);
      leave_grant  = (state == ST_GRANT) && (!bus.hs_access || timeout_hit);
      cnt_load     = enter_settle || leave_grant;
      cnt_load_val = enter_settle ? SETTLE_LOAD : RELEASE_LOAD;
      cnt_dec      = (state == ST_SETTLE) || (state == ST_RELEASE);
      sel_hs       = (state == ST_GRANT) || (state == ST_RELEASE);
   end

   hs_down_counter #(.WIDTH(CW)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // lockout keeps a force-released request from being re-granted until the
   // hiscore engine has dropped it at least once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         pause_q <= 1'b0;
         grant_q <= 1'b0;
         err_q   <= 1'b0;
         lockout <= 1'b0;
         tcnt    <= '0;
      end else begin
         if (!bus.hs_access)
            lockout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enter_settle) begin
                  state   <= ST_SETTLE;
                  pause_q <= 1'b1;
               end else if (bus.hs_access && !lockout) begin
                  state <= ST_WAIT_WIN;
               end
            end
            ST_WAIT_WIN: begin
               if (!bus.hs_access) begin
                  state <= ST_IDLE;
               end else if (enter_settle) begin
                  state   <= ST_SETTLE;
                  pause_q <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (!bus.hs_access) begin
                  state   <= ST_IDLE;
                  pause_q <= 1'b0;
               end else if (cnt_zero) begin
                  state   <= ST_GRANT;
                  grant_q <= 1'b1;
                  tcnt    <= '0;
               end
            end
            ST_GRANT: begin
               if (timeout_hit) begin
                  err_q   <= 1'b1;
                  lockout <= 1'b1;
               end
               if (leave_grant) begin
                  if (RELEASE_CYCLES == 0) begin
                     state   <= ST_IDLE;
                     pause_q <= 1'b0;
                     grant_q <= 1'b0;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end else if (tcnt != '1) begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            ST_RELEASE: begin
               if (bus.hs_access && !lockout) begin
                  state <= ST_GRANT;
                  tcnt  <= '0;
               end else if (cnt_zero) begin
                  state   <= ST_IDLE;
                  pause_q <= 1'b0;
                  grant_q <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               pause_q <= 1'b0;
               grant_q <= 1'b0;
            end
         endcase
      end
   end

   // Reset gates the RAM side so nothing is written while reset is held.
   always_comb begin
      addr_mux = sel_hs ? bus.hs_addr : bus.cpu_addr;
      din_mux  = sel_hs ? bus.hs_dout : bus.cpu_dout;
      we_mux   = sel_hs ? ((state == ST_GRANT) && bus.hs_write) : bus.cpu_we;
      if (reset) begin
         addr_mux = '0;
         din_mux  = '0;
         we_mux   = 1'b0;
      end
   end

   assign bus.ram_addr    = addr_mux;
   assign bus.ram_din     = din_mux;
   assign bus.ram_we      = we_mux;
   assign bus.cpu_din     = bus.ram_dout;
   assign bus.hs_din      = bus.ram_dout;
   assign bus.pause_cpu   = pause_q;
   assign bus.hs_grant    = grant_q;
   assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
module tb_hiscore_ram_arbiter;
   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   hiscore_ram_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus_a ();
   hiscore_ram_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus_b ();

   hiscore_ram_arbiter #(
      .ADDR_WIDTH(10), .DATA_WIDTH(8), .SETTLE_CYCLES(4), .RELEASE_CYCLES(2),
      .TIMEOUT_CYCLES(50), .USE_VBLANK(0)
   ) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a)
   );

   hiscore_ram_arbiter #(
      .ADDR_WIDTH(10), .DATA_WIDTH(8), .SETTLE_CYCLES(4), .RELEASE_CYCLES(0),
      .TIMEOUT_CYCLES(24'hFFFFFF), .USE_VBLANK(1)
   ) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bus_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 2 time units past the rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int err_at;
      logic any_p;

      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.cpu_addr = 10'h155; bus_a.cpu_dout = 8'hAA; bus_a.cpu_we = 1'b1;
      bus_a.hs_access = 1'b0;   bus_a.hs_write = 1'b0;
      bus_a.hs_addr = 10'h03A;  bus_a.hs_dout = 8'h5C;
      bus_a.vblank = 1'b0;      bus_a.ram_dout = 8'h77;
      bus_b.cpu_addr = 10'h2C1; bus_b.cpu_dout = 8'h11; bus_b.cpu_we = 1'b1;
      bus_b.hs_access = 1'b0;   bus_b.hs_write = 1'b0;
      bus_b.hs_addr = 10'h0F0;  bus_b.hs_dout = 8'h99;
      bus_b.vblank = 1'b0;      bus_b.ram_dout = 8'h42;
      #3;

      // reset state
      chk("rst_pause", bus_a.pause_cpu, 0);
      chk("rst_grant", bus_a.hs_grant, 0);
      chk("rst_err", bus_a.timeout_err, 0);
      chk("rst_ram_we", bus_a.ram_we, 0);
      chk("rst_ram_addr", bus_a.ram_addr, 0);
      chk("rst_cpu_din", bus_a.cpu_din, 8'h77);
      chk("rst_b_pause", bus_b.pause_cpu, 0);
      cyc(); cyc();
      rst_a = 1'b0;
      rst_b = 1'b0;
      cyc();
      chk("idle_ram_addr", bus_a.ram_addr, 10'h155);
      chk("idle_ram_din", bus_a.ram_din, 8'hAA);
      chk("idle_ram_we", bus_a.ram_we, 1);

      // request -> pause after 1 cycle, grant after 1+SETTLE_CYCLES
      bus_a.hs_access = 1'b1;
      #1;
      chk("req_pause_same_cycle", bus_a.pause_cpu, 0);
      cyc();
      chk("req_pause_1", bus_a.pause_cpu, 1);
      chk("req_grant_1", bus_a.hs_grant, 0);
      cyc(); cyc(); cyc();
      chk("settle_grant_4", bus_a.hs_grant, 0);
      chk("settle_addr_cpu", bus_a.ram_addr, 10'h155);
      cyc();
      chk("grant_at_5", bus_a.hs_grant, 1);
      chk("grant_addr_hs", bus_a.ram_addr, 10'h03A);
      chk("grant_we_idle", bus_a.ram_we, 0);
      bus_a.hs_write = 1'b1;
      #1;
      chk("grant_we", bus_a.ram_we, 1);
      chk("grant_din", bus_a.ram_din, 8'h5C);
      chk("grant_hs_din", bus_a.hs_din, 8'h77);

      // release: hiscore mux kept, writes off, pause drops after RELEASE+1
      bus_a.hs_access = 1'b0;
      cyc();
      chk("rel_grant_1", bus_a.hs_grant, 1);
      chk("rel_we_off", bus_a.ram_we, 0);
      chk("rel_addr_hs", bus_a.ram_addr, 10'h03A);
      cyc();
      chk("rel_pause_2", bus_a.pause_cpu, 1);
      cyc();
      chk("rel_pause_3", bus_a.pause_cpu, 0);
      chk("rel_grant_3", bus_a.hs_grant, 0);
      chk("rel_addr_cpu", bus_a.ram_addr, 10'h155);
      chk("rel_we_cpu", bus_a.ram_we, 1);
      bus_a.hs_write = 1'b0;

      // request dropped in cycle 2 of SETTLE -> no grant
      bus_a.hs_access = 1'b1;
      cyc();
      cyc();
      chk("abort_pause_held", bus_a.pause_cpu, 1);
      bus_a.hs_access = 1'b0;
      cyc();
      chk("abort_pause", bus_a.pause_cpu, 0);
      any_p = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         any_p = any_p | bus_a.hs_grant;
      end
      chk("abort_no_grant", any_p, 0);

      // re-request during RELEASE returns to GRANT without dropping pause
      bus_a.hs_access = 1'b1;
      repeat (5) cyc();
      chk("regrant_grant", bus_a.hs_grant, 1);
      bus_a.hs_access = 1'b0;
      cyc();
      bus_a.hs_access = 1'b1;
      cyc();
      chk("regrant_pause", bus_a.pause_cpu, 1);
      bus_a.hs_write = 1'b1;
      #1;
      chk("regrant_we", bus_a.ram_we, 1);
      bus_a.hs_access = 1'b0;
      bus_a.hs_write = 1'b0;
      repeat (3) cyc();
      chk("regrant_done", bus_a.pause_cpu, 0);
      chk("no_err_yet", bus_a.timeout_err, 0);

      // timeout: 50 grant cycles, then RELEASE_CYCLES more with grant held
      bus_a.hs_access = 1'b1;
      repeat (5) cyc();
      chk("to_grant", bus_a.hs_grant, 1);
      n = 0;
      err_at = -1;
      for (int i = 0; i < 200; i++) begin
         if (bus_a.hs_grant !== 1'b1) break;
         cyc();
         n++;
         if (err_at < 0 && bus_a.timeout_err === 1'b1) err_at = n;
      end
      chk("to_grant_len", n, 52);
      chk("to_err_cycle", err_at, 50);
      chk("to_pause", bus_a.pause_cpu, 0);
      chk("to_err", bus_a.timeout_err, 1);
      repeat (3) cyc();
      chk("to_no_regrant", bus_a.pause_cpu, 0);
      bus_a.hs_access = 1'b0;
      cyc();
      chk("to_err_sticky", bus_a.timeout_err, 1);

      // async reset mid-grant
      bus_a.hs_access = 1'b1;
      repeat (5) cyc();
      chk("rg_grant", bus_a.hs_grant, 1);
      bus_a.hs_write = 1'b1;
      #1;
      rst_a = 1'b1;
      #1;
      chk("rg_pause", bus_a.pause_cpu, 0);
      chk("rg_grant0", bus_a.hs_grant, 0);
      chk("rg_we", bus_a.ram_we, 0);
      chk("rg_err", bus_a.timeout_err, 0);
      cyc();
      rst_a = 1'b0;
      bus_a.hs_access = 1'b0;
      bus_a.hs_write = 1'b0;

      // vblank-gated grant, RELEASE_CYCLES = 0
      bus_b.hs_access = 1'b1;
      any_p = 1'b0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         any_p = any_p | bus_b.pause_cpu;
      end
      chk("vb_no_pause", any_p, 0);
      bus_b.vblank = 1'b1;
      cyc();
      chk("vb_pause", bus_b.pause_cpu, 1);
      bus_b.vblank = 1'b0;
      repeat (3) cyc();
      chk("vb_settle", bus_b.hs_grant, 0);
      cyc();
      chk("vb_grant", bus_b.hs_grant, 1);
      repeat (3) cyc();
      chk("vb_grant_kept", bus_b.hs_grant, 1);
      bus_b.hs_write = 1'b1;
      #1;
      chk("vb_we", bus_b.ram_we, 1);
      chk("vb_addr", bus_b.ram_addr, 10'h0F0);
      bus_b.hs_access = 1'b0;
      cyc();
      chk("vb_rel0_pause", bus_b.pause_cpu, 0);
      chk("vb_rel0_grant", bus_b.hs_grant, 0);
      chk("vb_rel0_addr", bus_b.ram_addr, 10'h2C1);
      bus_b.hs_write = 1'b0;

      // request withdrawn while waiting for vblank
      bus_b.hs_access = 1'b1;
      repeat (3) cyc();
      bus_b.hs_access = 1'b0;
      cyc();
      bus_b.vblank = 1'b1;
      repeat (2) cyc();
      chk("vb_withdraw", bus_b.pause_cpu, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
